quant_scheduler: RTL
====================

Name: quant_scheduler

Overview:
- Shares the single 8x8 quantizer datapath between three block requesters: Y, Cb and Cr.
- Arbitrates round-robin and reads each granted block's 64 DCT coefficients in zigzag order.
- Sequences the quantizer one coefficient at a time, selects the luma or chroma table, and emits quantized results tagged with zigzag index and channel for the entropy coder.

Parameters:
- TIMEOUT, 16, max cycles to wait for q_valid or q_done before aborting the block.
- DW, 16, coefficient width (signed).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  3  block-ready request; bit0=Y, bit1=Cb, bit2=Cr; level, held until blk_done/err for that channel
- gnt  out  3  one-hot grant; held for the whole block
- coef_addr  out  6  raster address into granted channel's coefficient RAM
- coef_data  in  DW  RAM read data; valid 1 cycle after coef_addr (sync RAM)
- q_start  out  1  1-cycle pulse opening a quantizer block
- q_din  out  DW  coefficient to quantizer; registered, stable until next issue
- q_table_sel  out  1  0=luma table (Y), 1=chroma table (Cb/Cr); stable for whole block
- q_valid  in  1  quantizer result strobe
- q_dout  in  DW  quantizer result
- q_done  in  1  quantizer end-of-block pulse
- out_valid  out  1  1-cycle result strobe
- out_data  out  DW  registered copy of q_dout
- out_zz_idx  out  6  zigzag index 0..63 of out_data
- out_chan  out  2  0=Y, 1=Cb, 2=Cr
- out_last  out  1  high with out_valid when out_zz_idx=63
- blk_done  out  1  1-cycle pulse, block completed normally
- err  out  1  1-cycle pulse, block aborted on timeout
- err_chan  out  2  channel of the aborted block; valid with err

Behaviour:
- Reset (async, rst_n=0): every output is 0; state=IDLE; RR pointer=Y; k=0.
- States: IDLE, START, FETCH, ISSUE, WAIT, EMIT, FINISH.
- IDLE:
  - If req≠0, grant the first requester at or after the RR pointer (order Y→Cb→Cr→Y).
  - gnt and q_table_sel are registered; go to START.
- START:
  - q_start=1 for exactly this cycle; k=0; coef_addr=ZZ[0]; go to FETCH.
- FETCH:
  - coef_addr=ZZ[k], where ZZ is the standard JPEG zigzag-to-raster ROM (ZZ[0]=0, ZZ[1]=1, ZZ[2]=8, ZZ[3]=16, ZZ[63]=63).
  - Go to ISSUE.
- ISSUE:
  - Capture coef_data into q_din; clear the timeout counter; go to WAIT.
- WAIT:
  - On q_valid: latch q_dout and go to EMIT.
  - Else increment the counter; when the counter reaches TIMEOUT, abort.
- EMIT:
  - out_valid=1, out_zz_idx=k, out_chan=granted channel, out_last=(k==63).
  - If k==63, go to FINISH; else k++ and go to FETCH.
- FINISH:
  - If q_done is seen, or was seen at any point during the block, blk_done=1.
  - gnt→0, RR pointer = granted channel + 1 (mod 3), go to IDLE.
  - Else count; on TIMEOUT, abort.
- Abort:
  - err=1 and err_chan=channel for 1 cycle, gnt→0.
  - RR pointer advances as for normal completion; go to IDLE.
  - No further out_valid for that block.
- Minimum per-coefficient spacing is 4 cycles (FETCH, ISSUE, WAIT≥1, EMIT).
- q_valid outside WAIT is ignored.
- req deasserting mid-block does not abort the block.
- Simultaneous requests are resolved only in IDLE.
- At least one idle cycle is inserted between blocks.
- Reset mid-block: all outputs drop to 0 immediately; no blk_done or err is emitted.
- out_data is a direct bit copy of q_dout; no width change.

Test Plan:
- Y only, req=001, quantizer model returns q_dout=coef, RAM[i]=i*10-320:
  - 64 out_valid pulses with out_zz_idx 0..63 and out_data=RAM[ZZ[k]] (k=2→RAM[8]=-240).
  - out_last only at idx 63; one blk_done; q_table_sel=0.
- req=111 held for 3 blocks:
  - Grant order Y, Cb, Cr, each a full 64 results.
  - q_table_sel=0,1,1; out_chan=0,1,2.
  - Re-held after all three: grant returns to Y.
- Fairness: Cb finishes while Y and Cr both request → next grant is Cr, not Y.
- Timeout: model withholds q_valid for coefficient k=5:
  - After 16 WAIT cycles, err pulse with err_chan=correct channel.
  - Exactly 5 outputs; gnt=0; no blk_done.
- Timeout on q_done: q_done never asserted → 64 outputs, then err after 16 cycles.
- Reset asserted at k=30:
  - All outputs 0 asynchronously; after release, a new req=001 starts at idx 0 with pointer=Y.

Source files
------------

// File: rtl/quant_scheduler.sv
// Round-robin scheduler sharing one 8x8 quantizer between Y/Cb/Cr block requesters.
// Reads each granted block in zigzag order and tags quantized results for the entropy coder.
module quant_scheduler #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned DW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    req,
    output logic [2:0]    gnt,
    output logic [5:0]    coef_addr,
    input  logic [DW-1:0] coef_data,
    output logic          q_start,
    output logic [DW-1:0] q_din,
    output logic          q_table_sel,
    input  logic          q_valid,
    input  logic [DW-1:0] q_dout,
    input  logic          q_done,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [5:0]    out_zz_idx,
    output logic [1:0]    out_chan,
    output logic          out_last,
    output logic          blk_done,
    output logic          err,
    output logic [1:0]    err_chan
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_FETCH, S_ISSUE, S_WAIT, S_EMIT, S_FINISH
    } state_t;

    localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    // Zigzag index -> raster address
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    state_t        state;
    logic [1:0]    rr_ptr;
    logic [1:0]    chan;
    logic [5:0]    k;
    logic [CW-1:0] cnt;
    logic          done_seen;

    logic [1:0]    c1, c2, pick_chan;
    logic          pick_valid;

    function automatic logic [1:0] nxt(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    always_comb begin
        c1         = nxt(rr_ptr);
        c2         = nxt(c1);
        pick_valid = 1'b1;
        pick_chan  = rr_ptr;
        if (req[rr_ptr])  pick_chan = rr_ptr;
        else if (req[c1]) pick_chan = c1;
        else if (req[c2]) pick_chan = c2;
        else              pick_valid = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            chan        <= '0;
            k           <= '0;
            cnt         <= '0;
            done_seen   <= 1'b0;
            gnt         <= '0;
            coef_addr   <= '0;
            q_start     <= 1'b0;
            q_din       <= '0;
            q_table_sel <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_zz_idx  <= '0;
            out_chan    <= '0;
            out_last    <= 1'b0;
            blk_done    <= 1'b0;
            err         <= 1'b0;
            err_chan    <= '0;
        end else begin
            q_start   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            blk_done  <= 1'b0;
            err       <= 1'b0;
            if (state != S_IDLE && q_done) done_seen <= 1'b1;

            case (state)
                S_IDLE: begin
                    // The cycle carrying blk_done/err is skipped so the requester can drop req
                    if (pick_valid && !blk_done && !err) begin
                        gnt         <= 3'b001 << pick_chan;
                        chan        <= pick_chan;
                        q_table_sel <= (pick_chan != 2'd0);
                        q_start     <= 1'b1;
                        done_seen   <= 1'b0;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    k         <= '0;
                    coef_addr <= ZZ[0];
                    state     <= S_FETCH;
                end
                S_FETCH: state <= S_ISSUE;
                S_ISSUE: begin
                    q_din <= coef_data;
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (q_valid) begin
                        out_data   <= q_dout;
                        out_valid  <= 1'b1;
                        out_zz_idx <= k;
                        out_chan   <= chan;
                        out_last   <= (k == 6'd63);
                        state      <= S_EMIT;
                    end else if (cnt == CNT_LAST) begin
                        err      <= 1'b1;
                        err_chan <= chan;
                        gnt      <= '0;
                        rr_ptr   <= nxt(chan);
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_EMIT: begin
                    if (k == 6'd63) begin
                        cnt   <= '0;
                        state <= S_FINISH;
                    end else begin
                        k         <= k + 6'd1;
                        coef_addr <= ZZ[k + 6'd1];
                        state     <= S_FETCH;
                    end
                end
                S_FINISH: begin
                    if (q_done || done_seen) begin
                        blk_done <= 1'b1;
                        gnt      <= '0;
                        rr_ptr   <= nxt(chan);
                        state    <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        err      <= 1'b1;
                        err_chan <= chan;
                        gnt      <= '0;
                        rr_ptr   <= nxt(chan);
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
